// File: rtl/halfdup_pkg.sv
// Shared types and constants for the half-duplex pin initiator.
package halfdup_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TURN,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RSP
  } state_t;

  localparam logic START_LEVEL = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/halfdup_pin_initiator_if.sv
// Core-side request/response handshake plus the split view of the bidirectional pin.
interface halfdup_pin_initiator_if #(
  parameter int DATA_W = 8
);

  // Handshake: a word moves on a rising edge where valid and ready are both high;
  // valid and its payload hold steady until that edge, and ready may be low at any time.
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_tmo;
  logic              pin_i;
  logic              pin_o;
  logic              pin_oe;

  modport master (
    input  req_valid, req_data, rsp_ready, pin_i,
    output req_ready, rsp_valid, rsp_data, rsp_tmo, pin_o, pin_oe
  );

  modport slave (
    output req_valid, req_data, rsp_ready, pin_i,
    input  req_ready, rsp_valid, rsp_data, rsp_tmo, pin_o, pin_oe
  );

endinterface

// File: rtl/halfdup_bit_timer.sv
// Loadable down-counter; done_o is high once the loaded count has run out.
module halfdup_bit_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Loading N-1 makes done_o rise on the Nth edge after the load.
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/halfdup_pin_initiator.sv
// Initiator of a single-wire half-duplex link: sends a framed request word,
// releases the pin, then receives the responder's framed reply or times out.
module halfdup_pin_initiator
  import halfdup_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CPB      = 4,
  parameter int TURN_CYC = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  halfdup_pin_initiator_if.master  bus,
  output state_t                   state_o
);

  localparam int RX_START_CYC = CPB + CPB / 2;
  localparam int TMR_W        = $clog2(max2(RX_START_CYC, TURN_CYC));
  localparam int BIT_W        = $clog2(DATA_W + 1);
  localparam int TMO_W        = $clog2(TIMEOUT + 1);

  localparam logic [TMR_W-1:0] LD_BIT   = TMR_W'(CPB - 1);
  localparam logic [TMR_W-1:0] LD_TURN  = TMR_W'(TURN_CYC - 1);
  localparam logic [TMR_W-1:0] LD_RXS   = TMR_W'(RX_START_CYC - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_tmo_q;
  logic              pin_o_q;
  logic              pin_oe_q;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_done;
  logic [DATA_W-1:0] rx_word;

  // Received bits enter at the MSB so the first (LSB) bit ends up at bit 0.
  assign rx_word = {bus.pin_i, shift_q[DATA_W-1:1]};

  halfdup_bit_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = LD_BIT;
    case (state_q)
      IDLE:     tmr_load = bus.req_valid;
      TX_START: tmr_load = tmr_done;
      TX_DATA: begin
        tmr_load = tmr_done;
        if (bit_q == LAST_BIT) tmr_val = LD_TURN;
      end
      RX_WAIT: begin
        tmr_load = (bus.pin_i == START_LEVEL);
        tmr_val  = LD_RXS;
      end
      RX_START: tmr_load = tmr_done;
      RX_DATA:  tmr_load = tmr_done && (bit_q != LAST_BIT);
      default:  tmr_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      tmo_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tmo_q   <= 1'b0;
      pin_o_q     <= 1'b0;
      pin_oe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            shift_q     <= bus.req_data;
            req_ready_q <= 1'b0;
            pin_oe_q    <= 1'b1;
            pin_o_q     <= START_LEVEL;
            state_q     <= TX_START;
          end
        end
        TX_START: begin
          if (tmr_done) begin
            pin_o_q <= shift_q[0];
            bit_q   <= '0;
            state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tmr_done) begin
            if (bit_q == LAST_BIT) begin
              pin_oe_q <= 1'b0;
              pin_o_q  <= 1'b0;
              state_q  <= TURN;
            end else begin
              pin_o_q <= shift_q[1];
              shift_q <= {1'b0, shift_q[DATA_W-1:1]};
              bit_q   <= bit_q + BIT_W'(1);
            end
          end
        end
        TURN: begin
          if (tmr_done) begin
            tmo_q   <= '0;
            state_q <= RX_WAIT;
          end
        end
        RX_WAIT: begin
          // A start bit on the last allowed cycle still wins over the timeout.
          if (bus.pin_i == START_LEVEL) begin
            bit_q   <= '0;
            state_q <= RX_START;
          end else if (tmo_q == TMO_LAST) begin
            rsp_valid_q <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= RSP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        RX_START: begin
          if (tmr_done) begin
            shift_q <= rx_word;
            bit_q   <= BIT_W'(1);
            state_q <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (tmr_done) begin
            if (bit_q == LAST_BIT) begin
              rsp_data_q  <= rx_word;
              rsp_tmo_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RSP;
            end else begin
              shift_q <= rx_word;
              bit_q   <= bit_q + BIT_W'(1);
            end
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tmo   = rsp_tmo_q;
  assign bus.pin_o     = pin_o_q;
  assign bus.pin_oe    = pin_oe_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_halfdup_pin_initiator.sv
// Bench for the half-duplex pin initiator: models the responder on pin_i and
// checks the pin waveform and response words against an expected queue.
module tb_halfdup_pin_initiator;
  import halfdup_pkg::*;

  localparam int DATA_W   = 8;
  localparam int CPB      = 4;
  localparam int TURN_CYC = 2;
  localparam int TIMEOUT  = 64;
  localparam int W        = DATA_W + 1;
  localparam int RX_LAT_BASE = 1 + CPB + CPB / 2 + (DATA_W - 1) * CPB;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state;

  always #5 clk = ~clk;

  halfdup_pin_initiator_if #(.DATA_W(DATA_W)) bus ();

  halfdup_pin_initiator #(
    .DATA_W   (DATA_W),
    .CPB      (CPB),
    .TURN_CYC (TURN_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Each entry is {rsp_tmo, rsp_data}.
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [DATA_W-1:0] d, input bit hold, output bit ok);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (bus.req_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (!bus.pin_oe) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (bus.rsp_valid) ok = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic respond(input logic [DATA_W-1:0] word, input int delay);
    repeat (delay) @(negedge clk);
    bus.pin_i = 1'b1;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < DATA_W; b++) begin
      bus.pin_i = word[b];
      repeat (CPB) @(negedge clk);
    end
    bus.pin_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ok;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    bus.pin_i     = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.pin_oe !== 1'b0 ||
        bus.pin_o !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b vld=%b oe=%b o=%b data=%h tmo=%b want 1 0 0 0 00 0",
               bus.req_ready, bus.rsp_valid, bus.pin_oe, bus.pin_o, bus.rsp_data, bus.rsp_tmo);
    end
    n_tests++;
    if (state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got %0d want %0d", state, IDLE);
    end
    rst = 1'b0;
    @(negedge clk);

    send_req(8'hFF, 1'b0, ok);
    repeat (8) @(negedge clk);
    n_tests++;
    if (!ok || state !== TX_DATA || bus.pin_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_tx got accepted=%b state=%0d oe=%b want 1 %0d 1", ok, state, bus.pin_oe, TX_DATA);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.pin_oe !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_tx got oe=%b rdy=%b vld=%b state=%0d want 0 1 0 %0d",
               bus.pin_oe, bus.req_ready, bus.rsp_valid, state, IDLE);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx();
    bit ok;
    int cyc;
    logic [DATA_W-1:0] word;
    logic exp_bit;
    logic [W-1:0] got, exp;
    word = 8'hA5;
    send_req(word, 1'b0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL tx_accept got accepted=0 want 1");
    end
    for (int i = 0; i < (1 + DATA_W) * CPB; i++) begin
      exp_bit = (i < CPB) ? 1'b1 : word[(i - CPB) / CPB];
      n_tests++;
      if (bus.pin_oe !== 1'b1 || bus.pin_o !== exp_bit) begin
        n_fail++;
        $display("FAIL tx_cycle_%0d got oe=%b o=%b want oe=1 o=%b", i, bus.pin_oe, bus.pin_o, exp_bit);
      end
      @(negedge clk);
    end
    n_tests++;
    if (bus.pin_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_release got oe=%b want 0", bus.pin_oe);
    end
    exp_q.push_back({1'b1, {DATA_W{1'b0}}});
    wait_rsp(cyc, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL tx_drain got no response want rsp_valid");
    end
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_tmo, bus.rsp_data};
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL tx_drain_word got %h want %h", got, exp);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_rx();
    bit ok, ok_r;
    int cyc;
    logic [W-1:0] got, exp;
    send_req(8'h11, 1'b0, ok);
    wait_release(ok_r);
    n_tests++;
    if (!ok || !ok_r) begin
      n_fail++;
      $display("FAIL rx_setup got accepted=%b released=%b want 1 1", ok, ok_r);
    end
    exp_q.push_back({1'b0, 8'h3C});
    fork
      respond(8'h3C, 5);
      wait_rsp(cyc, ok);
    join
    n_tests++;
    if (!ok || cyc != 5 + RX_LAT_BASE) begin
      n_fail++;
      $display("FAIL rx_latency got valid=%b cycles=%0d want 1 %0d", ok, cyc, 5 + RX_LAT_BASE);
    end
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_tmo, bus.rsp_data};
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL rx_word got %h want %h", got, exp);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok, ok_r;
    int cyc;
    logic [W-1:0] got, exp;
    send_req(8'h42, 1'b0, ok);
    wait_release(ok_r);
    n_tests++;
    if (!ok || !ok_r) begin
      n_fail++;
      $display("FAIL tmo_setup got accepted=%b released=%b want 1 1", ok, ok_r);
    end
    exp_q.push_back({1'b1, {DATA_W{1'b0}}});
    wait_rsp(cyc, ok);
    n_tests++;
    if (!ok || cyc != TURN_CYC + TIMEOUT) begin
      n_fail++;
      $display("FAIL tmo_latency got valid=%b cycles=%0d want 1 %0d", ok, cyc, TURN_CYC + TIMEOUT);
    end
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_tmo, bus.rsp_data};
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL tmo_word got %h want %h", got, exp);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok, ok_r;
    int cyc;
    logic [W-1:0] got, exp;
    send_req(8'h77, 1'b1, ok);
    wait_release(ok_r);
    n_tests++;
    if (!ok || !ok_r) begin
      n_fail++;
      $display("FAIL bp_setup got accepted=%b released=%b want 1 1", ok, ok_r);
    end
    bus.req_data = 8'h99;
    exp_q.push_back({1'b0, 8'h5A});
    fork
      respond(8'h5A, 3);
      wait_rsp(cyc, ok);
    join
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_tmo, bus.rsp_data} !== exp_q[0] || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got vld=%b word=%h rdy=%b want 1 %h 0",
                 i, bus.rsp_valid, {bus.rsp_tmo, bus.rsp_data}, bus.req_ready, exp_q[0]);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_tmo, bus.rsp_data};
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL bp_word got %h want %h", got, exp);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.pin_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_hs got rdy=%b vld=%b oe=%b want 1 0 0", bus.req_ready, bus.rsp_valid, bus.pin_oe);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_tests++;
    if (bus.req_ready !== 1'b0 || bus.pin_oe !== 1'b1 || state !== TX_START) begin
      n_fail++;
      $display("FAIL bp_pending_accept got rdy=%b oe=%b state=%0d want 0 1 %0d",
               bus.req_ready, bus.pin_oe, state, TX_START);
    end
    exp_q.push_back({1'b1, {DATA_W{1'b0}}});
    wait_release(ok_r);
    wait_rsp(cyc, ok);
    n_tests++;
    if (!ok || !ok_r) begin
      n_fail++;
      $display("FAIL bp_second got released=%b valid=%b want 1 1", ok_r, ok);
    end
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_tmo, bus.rsp_data};
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL bp_second_word got %h want %h", got, exp);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_turnaround();
    bit ok, ok_r;
    int cyc;
    logic [W-1:0] got, exp;
    send_req(8'hC3, 1'b0, ok);
    wait_release(ok_r);
    n_tests++;
    if (!ok || !ok_r) begin
      n_fail++;
      $display("FAIL turn_setup got accepted=%b released=%b want 1 1", ok, ok_r);
    end
    bus.pin_i = 1'b1;
    repeat (TURN_CYC) @(negedge clk);
    bus.pin_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (state !== RX_WAIT) begin
      n_fail++;
      $display("FAIL turn_ignore got state=%0d want %0d", state, RX_WAIT);
    end
    // Start bit lands on the last of the TIMEOUT waiting cycles.
    exp_q.push_back({1'b0, 8'h96});
    fork
      respond(8'h96, TIMEOUT - 2);
      wait_rsp(cyc, ok);
    join
    n_tests++;
    if (!ok || cyc != TIMEOUT - 2 + RX_LAT_BASE) begin
      n_fail++;
      $display("FAIL turn_edge_latency got valid=%b cycles=%0d want 1 %0d", ok, cyc, TIMEOUT - 2 + RX_LAT_BASE);
    end
    bus.rsp_ready = 1'b1;
    got = {bus.rsp_tmo, bus.rsp_data};
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL turn_edge_word got %h want %h", got, exp);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_timeout();
    test_back_to_back();
    test_turnaround();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
